// File: rtl/rcvbuffer_pkg.sv
// Shared constants and FSM encoding for the receive frame buffer.
package rcvbuffer_pkg;

   localparam int RX_NBYTES  = 1250;
   localparam int FRAME_BITS = 8 * RX_NBYTES;
   localparam int PTR_W      = 11;

   typedef enum logic [2:0] {
      FILL_REQ = 3'd0,
      FILL_ACK = 3'd1,
      FULL     = 3'd2,
      SEND     = 3'd3,
      DONE     = 3'd4
   } rx_state_e;

endpackage

// File: rtl/rcvbuffer_if.sv
// Fill handshake from buffer_control plus the serial replay outputs toward the loopback.
interface rcvbuffer_if;

   logic [7:0] datain;
   logic       dav_rx;
   logic       send;
   logic       rfd_rx;
   logic       ack_rx;
   logic       rx_full;
   logic       rx_empty;
   logic       start;
   logic       dataout;

   modport master (
      output datain, dav_rx, send,
      input  rfd_rx, ack_rx, rx_full, rx_empty, start, dataout
   );

   modport slave (
      input  datain, dav_rx, send,
      output rfd_rx, ack_rx, rx_full, rx_empty, start, dataout
   );

endinterface

// File: rtl/rcvbuffer_mem.sv
// Frame byte store: synchronous write, combinational read; kept apart so a RAM macro can drop in.
module rcv_mem
   import rcvbuffer_pkg::*;
#(
   parameter int NBYTES = RX_NBYTES
) (
   input  logic             clk_1200,
   input  logic             we,
   input  logic [PTR_W-1:0] waddr,
   input  logic [7:0]       wdata,
   input  logic [PTR_W-1:0] raddr,
   output logic [7:0]       rdata
);

   localparam int AW = (NBYTES > 1) ? $clog2(NBYTES) : 1;

   logic [7:0] mem [NBYTES];

   always_ff @(posedge clk_1200) begin
      if (we) begin
         mem[waddr[AW-1:0]] <= wdata;
      end
   end

   assign rdata = mem[raddr[AW-1:0]];

endmodule

// File: rtl/rcvbuffer.sv
// Stores one frame via a four-phase dav/ack fill, then replays it LSB-first, one bit per clk_1200.
// All outputs are registered; start and bit 0 appear the cycle after send is seen in FULL.
module rcvbuffer
   import rcvbuffer_pkg::*;
#(
   parameter int NBYTES = RX_NBYTES
) (
   input  logic       clk_1200,
   input  logic       reset,
   rcvbuffer_if.slave rx
);

   localparam logic [PTR_W-1:0] LAST = PTR_W'(NBYTES - 1);

   rx_state_e        state, state_n;
   logic [PTR_W-1:0] wptr, wptr_n, rptr, rptr_n, raddr;
   logic [2:0]       bidx, bidx_n;
   logic             rfd_q, rfd_n, ack_q, ack_n, full_q, full_n;
   logic             empty_q, empty_n, start_q, start_n, dout_q, dout_n;
   logic             mem_we;
   logic [7:0]       rd_byte;

   // FULL always launches from byte 0, so only SEND needs the live read pointer.
   assign raddr = (state == SEND) ? rptr : '0;

   rcv_mem #(.NBYTES(NBYTES)) u_mem (
      .clk_1200 (clk_1200),
      .we       (mem_we),
      .waddr    (wptr),
      .wdata    (rx.datain),
      .raddr    (raddr),
      .rdata    (rd_byte)
   );

   always_comb begin
      state_n = state;
      wptr_n  = wptr;
      rptr_n  = rptr;
      bidx_n  = bidx;
      rfd_n   = rfd_q;
      ack_n   = ack_q;
      full_n  = full_q;
      empty_n = 1'b0;
      start_n = 1'b0;
      dout_n  = 1'b0;
      mem_we  = 1'b0;
      case (state)
         FILL_REQ: begin
            if (rx.dav_rx) begin
               mem_we  = 1'b1;
               rfd_n   = 1'b0;
               ack_n   = 1'b1;
               state_n = FILL_ACK;
            end else begin
               rfd_n = 1'b1;
            end
         end
         FILL_ACK: begin
            if (!rx.dav_rx) begin
               ack_n  = 1'b0;
               wptr_n = wptr + 1'b1;
               if (wptr == LAST) begin
                  full_n  = 1'b1;
                  state_n = FULL;
               end else begin
                  state_n = FILL_REQ;
               end
            end
         end
         FULL: begin
            rfd_n = 1'b0;
            if (rx.send) begin
               full_n  = 1'b0;
               start_n = 1'b1;
               dout_n  = rd_byte[0];
               rptr_n  = '0;
               bidx_n  = 3'd1;
               state_n = SEND;
            end
         end
         SEND: begin
            dout_n = rd_byte[bidx];
            bidx_n = bidx + 3'd1;
            if (bidx == 3'd7) begin
               rptr_n = rptr + 1'b1;
               if (rptr == LAST) begin
                  state_n = DONE;
               end
            end
         end
         DONE: begin
            empty_n = 1'b1;
            wptr_n  = '0;
            state_n = FILL_REQ;
         end
         default: state_n = FILL_REQ;
      endcase
   end

   always_ff @(posedge clk_1200 or posedge reset) begin
      if (reset) begin
         state   <= FILL_REQ;
         wptr    <= '0;
         rptr    <= '0;
         bidx    <= '0;
         rfd_q   <= 1'b0;
         ack_q   <= 1'b0;
         full_q  <= 1'b0;
         empty_q <= 1'b0;
         start_q <= 1'b0;
         dout_q  <= 1'b0;
      end else begin
         state   <= state_n;
         wptr    <= wptr_n;
         rptr    <= rptr_n;
         bidx    <= bidx_n;
         rfd_q   <= rfd_n;
         ack_q   <= ack_n;
         full_q  <= full_n;
         empty_q <= empty_n;
         start_q <= start_n;
         dout_q  <= dout_n;
      end
   end

   assign rx.rfd_rx   = rfd_q;
   assign rx.ack_rx   = ack_q;
   assign rx.rx_full  = full_q;
   assign rx.rx_empty = empty_q;
   assign rx.start    = start_q;
   assign rx.dataout  = dout_q;

endmodule

// File: tb/tb_rcvbuffer.sv
// Directed bench: a 4-byte instance for handshake/order detail and a default-size instance for full frames.
module tb_rcvbuffer;
   import rcvbuffer_pkg::*;

   localparam int SMALL = 4;

   logic       clk_1200 = 1'b0;
   logic       rst_s, rst_b, sel;
   logic [7:0] datain;
   logic       dav, send;

   always #5 clk_1200 = ~clk_1200;

   rcvbuffer_if s_if ();
   rcvbuffer_if b_if ();

   assign s_if.datain = datain;
   assign s_if.dav_rx = dav & ~sel;
   assign s_if.send   = send & ~sel;
   assign b_if.datain = datain;
   assign b_if.dav_rx = dav & sel;
   assign b_if.send   = send & sel;

   rcvbuffer #(.NBYTES(SMALL)) dut_s (.clk_1200(clk_1200), .reset(rst_s), .rx(s_if.slave));
   rcvbuffer dut_b (.clk_1200(clk_1200), .reset(rst_b), .rx(b_if.slave));

   logic o_rfd, o_ack, o_full, o_empty, o_start, o_dout;
   assign o_rfd   = sel ? b_if.rfd_rx   : s_if.rfd_rx;
   assign o_ack   = sel ? b_if.ack_rx   : s_if.ack_rx;
   assign o_full  = sel ? b_if.rx_full  : s_if.rx_full;
   assign o_empty = sel ? b_if.rx_empty : s_if.rx_empty;
   assign o_start = sel ? b_if.start    : s_if.start;
   assign o_dout  = sel ? b_if.dataout  : s_if.dataout;

   logic [5:0] outs;
   assign outs = {o_rfd, o_ack, o_full, o_empty, o_start, o_dout};

   int total = 0;
   int bad   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Counts ack rising edges on the selected instance.
   int   ack_cnt  = 0;
   logic ack_prev = 1'b0;
   always @(posedge clk_1200) begin
      if (o_ack && !ack_prev) ack_cnt++;
      ack_prev = o_ack;
   end

   function automatic logic [7:0] exp_byte(input int pat, input int i);
      logic [7:0] v;
      v = i[7:0];
      case (pat)
         0: begin
            case (i)
               0:       return 8'hA5;
               1:       return 8'h3C;
               2:       return 8'hFF;
               default: return 8'h01;
            endcase
         end
         1:       return v;
         default: return ~v;
      endcase
   endfunction

   task automatic put_byte(input logic [7:0] b, input int hold);
      int n;
      n = 0;
      while (!o_rfd && n < 50) begin
         @(negedge clk_1200);
         n++;
      end
      if (n == 50) check("rfd_wait_timeout", 0, 1);
      datain = b;
      dav    = 1'b1;
      repeat (hold) @(negedge clk_1200);
      dav = 1'b0;
      n   = 0;
      do begin
         @(negedge clk_1200);
         n++;
      end while (o_ack && n < 50);
      if (n == 50) check("ack_drop_timeout", 1, 0);
   endtask

   task automatic fill_frame(input int nb, input int pat);
      for (int i = 0; i < nb; i++) begin
         put_byte(exp_byte(pat, i), (pat == 0) ? ((2 * i) % 5) + 1 : 1);
         if (i == nb - 2) check("full_not_early", o_full, 0);
      end
      check("full_set", o_full, 1);
   endtask

   logic rx_bits [FRAME_BITS];
   int   nbits, n_start, start_cyc, n_empty, empty_cyc;

   task automatic replay(input int max_cyc, input int stop_at);
      send      = 1'b1;
      nbits     = 0;
      n_start   = 0;
      start_cyc = 0;
      n_empty   = 0;
      empty_cyc = 0;
      for (int c = 1; c <= max_cyc; c++) begin
         @(negedge clk_1200);
         if (c == 2) send = 1'b0;
         if (o_start) begin
            n_start++;
            if (start_cyc == 0) start_cyc = c;
         end
         if (o_empty) begin
            n_empty++;
            if (empty_cyc == 0) empty_cyc = c;
         end else if (n_empty == 0 && start_cyc != 0 && nbits < FRAME_BITS) begin
            rx_bits[nbits] = o_dout;
            nbits++;
         end
         if (stop_at > 0 && c == stop_at) break;
         if (n_empty > 0 && c > empty_cyc + 1) break;
      end
      if (stop_at == 0 && empty_cyc == 0) check("empty_timeout", 0, 1);
   endtask

   function automatic logic [7:0] got_byte(input int i);
      logic [7:0] b;
      for (int j = 0; j < 8; j++) b[j] = rx_bits[8 * i + j];
      return b;
   endfunction

   function automatic int bad_bytes(input int nb, input int pat);
      int e;
      e = 0;
      for (int i = 0; i < nb; i++) begin
         if (got_byte(i) !== exp_byte(pat, i)) e++;
      end
      return e;
   endfunction

   initial begin
      int a0, e;
      sel    = 1'b0;
      rst_s  = 1'b1;
      rst_b  = 1'b1;
      dav    = 1'b0;
      send   = 1'b0;
      datain = 8'h00;

      // Reset behaviour on the small instance
      repeat (3) @(negedge clk_1200);
      check("reset_outs", outs, 6'b000000);
      rst_s = 1'b0;
      @(negedge clk_1200);
      check("rfd_after_release", outs, 6'b100000);
      datain = 8'h5A;
      dav    = 1'b1;
      @(negedge clk_1200);
      check("ack_latency", outs, 6'b010000);
      #2 rst_s = 1'b1;
      #1 check("async_reset_outs", outs, 6'b000000);
      dav = 1'b0;
      @(negedge clk_1200);
      rst_s = 1'b0;
      @(negedge clk_1200);
      check("rfd_after_midclk_reset", outs, 6'b100000);

      // Fill handshake with varying dav hold times
      a0 = ack_cnt;
      fill_frame(SMALL, 0);
      check("ack_count_small", ack_cnt - a0, SMALL);
      repeat (3) @(negedge clk_1200);
      check("full_idle_outs", outs, 6'b001000);

      // Extra data while full is ignored
      a0     = ack_cnt;
      datain = 8'h77;
      dav    = 1'b1;
      repeat (2) @(negedge clk_1200);
      dav = 1'b0;
      repeat (2) @(negedge clk_1200);
      check("no_ack_in_full", ack_cnt - a0, 0);
      check("still_full", outs, 6'b001000);

      // Replay order
      replay(60, 0);
      check("start_count", n_start, 1);
      check("start_cycle", start_cyc, 1);
      check("bits_small", nbits, 8 * SMALL);
      for (int i = 0; i < SMALL; i++) check($sformatf("byte%0d", i), got_byte(i), exp_byte(0, i));
      check("empty_count", n_empty, 1);
      check("empty_cycle", empty_cyc, 8 * SMALL + 1);
      check("idle_after_done", outs, 6'b100000);

      // Full default-size frame
      sel = 1'b1;
      @(negedge clk_1200);
      rst_b = 1'b0;
      @(negedge clk_1200);
      check("big_rfd", outs, 6'b100000);
      a0 = ack_cnt;
      fill_frame(RX_NBYTES, 1);
      @(negedge clk_1200);
      check("ack_count_big", ack_cnt - a0, RX_NBYTES);
      replay(FRAME_BITS + 20, 0);
      check("bits_big", nbits, FRAME_BITS);
      check("bad_bytes_big", bad_bytes(RX_NBYTES, 1), 0);
      check("last_byte", got_byte(RX_NBYTES - 1), 8'hE1);
      check("start_count_big", n_start, 1);
      check("empty_cycle_big", empty_cyc, FRAME_BITS + 1);

      // Reset in the middle of replay
      fill_frame(RX_NBYTES, 1);
      replay(FRAME_BITS + 20, 5001);
      check("bits_before_reset", nbits, 5001);
      #2 rst_b = 1'b1;
      #1 check("midreplay_reset_outs", outs, 6'b000000);
      e = n_empty;
      repeat (4) begin
         @(negedge clk_1200);
         if (o_empty) e++;
      end
      rst_b = 1'b0;
      repeat (4) begin
         @(negedge clk_1200);
         if (o_empty) e++;
      end
      check("no_empty_after_reset", e, 0);

      // Next fill restarts at address 0
      fill_frame(RX_NBYTES, 2);
      replay(FRAME_BITS + 20, 0);
      check("bits_refill", nbits, FRAME_BITS);
      check("bad_bytes_refill", bad_bytes(RX_NBYTES, 2), 0);
      check("first_byte_refill", got_byte(0), 8'hFF);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
